// File: rtl/div_arbiter_pkg.sv
// Shared types for the divider arbiter: FSM states, port id and divide-by-zero constant.
// Consumed by div_arbiter and div_sign_fix; optional signed support is DIV_SIGNED_EN.
package div_arbiter_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef logic port_t;

   localparam logic [DIV_WIDTH-1:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/div_sign_fix.sv
// Combinational sign handling around the unsigned divider: operand magnitudes before
// issue and quotient/remainder sign restoration after completion (DIV_SIGNED_EN).
module div_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             neg_q,
   input  logic             neg_r,
   input  logic [WIDTH-1:0] raw_q,
   input  logic [WIDTH-1:0] raw_r,
   output logic [WIDTH-1:0] mag_dividend,
   output logic [WIDTH-1:0] mag_divisor,
   output logic             dividend_neg,
   output logic             divisor_neg,
   output logic [WIDTH-1:0] fix_q,
   output logic [WIDTH-1:0] fix_r
);

`ifdef DIV_SIGNED_EN
   assign dividend_neg = is_signed & dividend[WIDTH-1];
   assign divisor_neg  = is_signed & divisor[WIDTH-1];
   // -2^31 maps onto itself, which is exactly the unsigned magnitude 0x8000_0000.
   assign mag_dividend = dividend_neg ? -dividend : dividend;
   assign mag_divisor  = divisor_neg  ? -divisor  : divisor;
   assign fix_q        = neg_q ? -raw_q : raw_q;
   assign fix_r        = neg_r ? -raw_r : raw_r;
`else
   logic unused_sign_inputs;
   assign unused_sign_inputs = is_signed ^ neg_q ^ neg_r;
   assign dividend_neg = 1'b0;
   assign divisor_neg  = 1'b0;
   assign mag_dividend = dividend;
   assign mag_divisor  = divisor;
   assign fix_q        = raw_q;
   assign fix_r        = raw_r;
`endif

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative divider between two requesters, with local
// divide-by-zero handling. Signed DIV support is compiled in with DIV_SIGNED_EN.
module div_arbiter
   import div_arbiter_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             r0_valid,
   output logic             r0_ready,
   input  logic [WIDTH-1:0] r0_dividend,
   input  logic [WIDTH-1:0] r0_divisor,
   input  logic             r0_signed,
   input  logic             r1_valid,
   output logic             r1_ready,
   input  logic [WIDTH-1:0] r1_dividend,
   input  logic [WIDTH-1:0] r1_divisor,
   input  logic             r1_signed,
   output logic             rsp0_valid,
   output logic             rsp1_valid,
   output logic [WIDTH-1:0] rsp_q,
   output logic [WIDTH-1:0] rsp_r,
   output logic             rsp_dz,
   output logic [WIDTH-1:0] dv_dividend,
   output logic [WIDTH-1:0] dv_divisor,
   output logic             dv_start,
   input  logic             dv_done,
   input  logic [WIDTH-1:0] dv_q,
   input  logic [WIDTH-1:0] dv_r,
   output state_t           state
);

   // Handshake: a request is taken on the rising edge where rN_valid and rN_ready are
   // both high; ready is only offered in IDLE and valid must stay high until then.
   state_t           state_next;
   port_t            last;
   port_t            cap_port;
   port_t            grant;
   logic             grant_any;
   logic             accept;
   logic             sel_zero;
   logic             cap_neg_q;
   logic             cap_neg_r;
   logic [WIDTH-1:0] sel_dividend;
   logic [WIDTH-1:0] sel_divisor;
   logic             sel_signed;
   logic [WIDTH-1:0] mag_dividend;
   logic [WIDTH-1:0] mag_divisor;
   logic             dividend_neg;
   logic             divisor_neg;
   logic [WIDTH-1:0] fix_q;
   logic [WIDTH-1:0] fix_r;

   always_comb begin
      grant_any = r0_valid | r1_valid;
      if (r0_valid && r1_valid) grant = ~last;
      else                      grant = r1_valid;
   end

   assign sel_dividend = grant ? r1_dividend : r0_dividend;
   assign sel_divisor  = grant ? r1_divisor  : r0_divisor;
   assign sel_signed   = grant ? r1_signed   : r0_signed;
   assign sel_zero     = (sel_divisor == '0);

   assign accept     = (state == IDLE) & grant_any;
   assign r0_ready   = accept & ~grant;
   assign r1_ready   = accept & grant;
   assign dv_start   = (state == ISSUE);
   assign rsp0_valid = (state == RESP) & ~cap_port;
   assign rsp1_valid = (state == RESP) & cap_port;

   div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
      .is_signed    (sel_signed),
      .dividend     (sel_dividend),
      .divisor      (sel_divisor),
      .neg_q        (cap_neg_q),
      .neg_r        (cap_neg_r),
      .raw_q        (dv_q),
      .raw_r        (dv_r),
      .mag_dividend (mag_dividend),
      .mag_divisor  (mag_divisor),
      .dividend_neg (dividend_neg),
      .divisor_neg  (divisor_neg),
      .fix_q        (fix_q),
      .fix_r        (fix_r)
   );

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = sel_zero ? RESP : ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT:    if (dv_done) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         last        <= 1'b1;
         cap_port    <= 1'b0;
         cap_neg_q   <= 1'b0;
         cap_neg_r   <= 1'b0;
         dv_dividend <= '0;
         dv_divisor  <= '0;
         rsp_q       <= '0;
         rsp_r       <= '0;
         rsp_dz      <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            last      <= grant;
            cap_port  <= grant;
            cap_neg_q <= dividend_neg ^ divisor_neg;
            cap_neg_r <= dividend_neg;
            // Divide-by-zero answers immediately; the divider operands are left untouched.
            if (sel_zero) begin
               rsp_q  <= WIDTH'(DZ_QUOTIENT);
               rsp_r  <= sel_dividend;
               rsp_dz <= 1'b1;
            end else begin
               dv_dividend <= mag_dividend;
               dv_divisor  <= mag_divisor;
            end
         end
         if ((state == WAIT) && dv_done) begin
            rsp_q  <= fix_q;
            rsp_r  <= fix_r;
            rsp_dz <= 1'b0;
         end
      end
   end

endmodule
